// File: rtl/stencil_window_gen_if.sv
// ----------------------------------------------------------------------------
// stencil_window_gen_if
// Stream bundle for the stencil window generator.
//   s_axis_temp_*  : input temperature stream (data, valid, ready)
//   m_axis_temp_*  : output window stream (data, valid, ready, last, user)
// Modports:
//   master : the generator side (consumes s_axis, produces m_axis)
//   slave  : the environment side (produces s_axis, consumes m_axis)
// ----------------------------------------------------------------------------
interface stencil_window_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   s_axis_temp_data;
  logic                    s_axis_temp_valid;
  logic                    s_axis_temp_ready;
  logic [5*DATA_WIDTH-1:0] m_axis_temp_data;
  logic                    m_axis_temp_valid;
  logic                    m_axis_temp_ready;
  logic                    m_axis_temp_last;
  logic                    m_axis_temp_user;

  modport master (
    input  s_axis_temp_data, s_axis_temp_valid, m_axis_temp_ready,
    output s_axis_temp_ready, m_axis_temp_data, m_axis_temp_valid,
           m_axis_temp_last, m_axis_temp_user
  );

  modport slave (
    output s_axis_temp_data, s_axis_temp_valid, m_axis_temp_ready,
    input  s_axis_temp_ready, m_axis_temp_data, m_axis_temp_valid,
           m_axis_temp_last, m_axis_temp_user
  );
endinterface

// File: rtl/stencil_window_gen.sv
// ----------------------------------------------------------------------------
// stencil_window_gen
// Runtime-configurable 5-point stencil window generator. Takes a row-major
// stream of grid samples and emits one {center, north, south, east, west}
// window per cell in raster order, clamping missing neighbours to center.
// Ports:
//   aclk, axi_reset     : clock, synchronous active-high reset
//   cfg_cols, cfg_rows  : grid width C (2..MAX_COLS) and height R (>=2)
//   start               : frame start request (sampled in IDLE only)
//   busy                : frame in progress
//   cfg_err             : one-cycle pulse on a rejected start
//   axis                : input sample stream and output window stream
// ----------------------------------------------------------------------------
module stencil_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_COLS   = 512,
  parameter int COL_BITS   = 10,
  parameter int ROW_BITS   = 10
) (
  input  logic                aclk,
  input  logic                axi_reset,
  input  logic [COL_BITS-1:0] cfg_cols,
  input  logic [ROW_BITS-1:0] cfg_rows,
  input  logic                start,
  output logic                busy,
  output logic                cfg_err,
  stencil_window_gen_if.master axis
);

  localparam int DEPTH = 2*MAX_COLS + 1;
  localparam int IDX_W = COL_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [COL_BITS-1:0]     cols_q, in_col_q, out_col_q;
  logic [ROW_BITS-1:0]     rows_q, in_row_q, out_row_q;
  logic [DATA_WIDTH-1:0]   shift_q [DEPTH];
  logic [5*DATA_WIDTH-1:0] m_data_q;
  logic                    m_valid_q, m_last_q, m_user_q;
  logic                    busy_q, cfg_err_q;

  logic cfg_legal_s, start_ok_s, load_ok_s, s_ready_s, in_fire_s, out_fire_s;
  logic flush_adv_s, shift_s, emit_s;
  logic in_last_col_s, in_last_row_s, out_last_col_s, out_last_row_s;
  logic [IDX_W-1:0] cols_ext_s, c_idx_s, n_idx_s, e_idx_s, w_idx_s;
  logic [DATA_WIDTH-1:0] center_s, north_s, south_s, east_s, west_s;

  assign cfg_legal_s = (cfg_cols >= COL_BITS'(2)) && (cfg_cols <= COL_BITS'(MAX_COLS))
                       && (cfg_rows >= ROW_BITS'(2));
  assign start_ok_s  = start && (state_q == IDLE) && cfg_legal_s;
  assign load_ok_s   = !m_valid_q || axis.m_axis_temp_ready;
  assign s_ready_s   = ((state_q == FILL) || (state_q == RUN)) && load_ok_s;
  assign in_fire_s   = axis.s_axis_temp_valid && s_ready_s;
  assign out_fire_s  = m_valid_q && axis.m_axis_temp_ready;
  // Once the last window is loaded, FLUSH stops advancing until it is taken.
  assign flush_adv_s = (state_q == FLUSH) && load_ok_s && !(m_valid_q && m_last_q);
  assign shift_s     = in_fire_s || flush_adv_s;
  assign emit_s      = (in_fire_s && (state_q == RUN)) || flush_adv_s;

  assign in_last_col_s  = (in_col_q  == cols_q - COL_BITS'(1));
  assign in_last_row_s  = (in_row_q  == rows_q - ROW_BITS'(1));
  assign out_last_col_s = (out_col_q == cols_q - COL_BITS'(1));
  assign out_last_row_s = (out_row_q == rows_q - ROW_BITS'(1));

  // Taps are read as if the current shift had already happened: tap j of the
  // post-shift buffer is shift_q[j-1], and tap 0 is the incoming sample.
  assign cols_ext_s = {1'b0, cols_q};
  assign c_idx_s    = cols_ext_s - IDX_W'(1);
  assign n_idx_s    = (cols_ext_s << 1) - IDX_W'(1);
  assign e_idx_s    = cols_ext_s - IDX_W'(2);
  assign w_idx_s    = cols_ext_s;

  assign center_s = shift_q[c_idx_s];
  assign north_s  = (out_row_q == ROW_BITS'(0)) ? center_s : shift_q[n_idx_s];
  assign south_s  = out_last_row_s ? center_s : axis.s_axis_temp_data;
  assign east_s   = out_last_col_s ? center_s : shift_q[e_idx_s];
  assign west_s   = (out_col_q == COL_BITS'(0)) ? center_s : shift_q[w_idx_s];

  // State register.
  always_ff @(posedge aclk) begin
    if (axi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok_s) state_d = FILL; else state_d = IDLE;
      FILL:    if (in_fire_s && in_last_col_s) state_d = RUN; else state_d = FILL;
      RUN:     if (in_fire_s && in_last_col_s && in_last_row_s) state_d = FLUSH;
               else state_d = RUN;
      FLUSH:   if (out_fire_s && m_last_q) state_d = IDLE; else state_d = FLUSH;
      default: state_d = IDLE;
    endcase
  end

  // Frame geometry latch and input/output position counters.
  always_ff @(posedge aclk) begin
    if (axi_reset) begin
      cols_q    <= COL_BITS'(2);
      rows_q    <= ROW_BITS'(2);
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else if (start_ok_s) begin
      cols_q    <= cfg_cols;
      rows_q    <= cfg_rows;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      if (in_fire_s) begin
        if (in_last_col_s) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + ROW_BITS'(1);
        end else begin
          in_col_q <= in_col_q + COL_BITS'(1);
        end
      end
      if (emit_s) begin
        if (out_last_col_s) begin
          out_col_q <= '0;
          out_row_q <= out_row_q + ROW_BITS'(1);
        end else begin
          out_col_q <= out_col_q + COL_BITS'(1);
        end
      end
    end
  end

  // Sample shift buffer; contents are never reset since clamping hides stale data.
  always_ff @(posedge aclk) begin
    if (shift_s) begin
      for (int i = DEPTH-1; i > 0; i--) shift_q[i] <= shift_q[i-1];
      shift_q[0] <= axis.s_axis_temp_data;
    end
  end

  // Output window register with stream hold semantics.
  always_ff @(posedge aclk) begin
    if (axi_reset) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
    end else if (emit_s) begin
      m_data_q  <= {center_s, north_s, south_s, east_s, west_s};
      m_valid_q <= 1'b1;
      m_last_q  <= out_last_row_s && out_last_col_s;
      m_user_q  <= (out_row_q == ROW_BITS'(0)) && (out_col_q == COL_BITS'(0));
    end else if (axis.m_axis_temp_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Status outputs: busy follows the next state, cfg_err pulses on a rejected start.
  always_ff @(posedge aclk) begin
    if (axi_reset) begin
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      busy_q    <= (state_d != IDLE);
      cfg_err_q <= start && (state_q == IDLE) && !cfg_legal_s;
    end
  end

  assign busy                   = busy_q;
  assign cfg_err                = cfg_err_q;
  assign axis.s_axis_temp_ready = s_ready_s;
  assign axis.m_axis_temp_data  = m_data_q;
  assign axis.m_axis_temp_valid = m_valid_q;
  assign axis.m_axis_temp_last  = m_last_q;
  assign axis.m_axis_temp_user  = m_user_q;

endmodule

// File: tb/tb_stencil_window_gen.sv
// ----------------------------------------------------------------------------
// tb_stencil_window_gen
// Self-checking bench for stencil_window_gen. Windows are predicted from a
// 2-D grid model with clamped neighbours and compared beat by beat.
// ----------------------------------------------------------------------------
module tb_stencil_window_gen;
  localparam int DW = 32;
  localparam int MAXC = 512;
  localparam int CB = 10;
  localparam int RB = 10;

  logic          aclk = 1'b0;
  logic          axi_reset;
  logic [CB-1:0] cfg_cols;
  logic [RB-1:0] cfg_rows;
  logic          start, busy, cfg_err;

  stencil_window_gen_if #(.DATA_WIDTH(DW)) axis_if ();

  stencil_window_gen #(.DATA_WIDTH(DW), .MAX_COLS(MAXC), .COL_BITS(CB), .ROW_BITS(RB)) dut (
    .aclk(aclk), .axi_reset(axi_reset), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .start(start), .busy(busy), .cfg_err(cfg_err), .axis(axis_if)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_bad   = 0;
  int unsigned t_mem [1024];
  logic [161:0] exp_q [$];
  int           spot_idx [$];
  logic [161:0] spot_val [$];

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [161:0] win(input bit l, input bit u, input int unsigned ce,
      input int unsigned no, input int unsigned so, input int unsigned ea, input int unsigned we);
    return {l, u, ce, no, so, ea, we};
  endfunction

  // Grid model: fill the grid, then list every window in raster order.
  task automatic build_exp(input int c, input int r, input bit rnd);
    int unsigned ce, no, so, ea, we;
    exp_q.delete();
    for (int k = 0; k < c*r; k++) t_mem[k] = rnd ? $urandom : k;
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < c; cc++) begin
        ce = t_mem[rr*c + cc];
        no = (rr == 0)     ? ce : t_mem[(rr-1)*c + cc];
        so = (rr == r-1)   ? ce : t_mem[(rr+1)*c + cc];
        we = (cc == 0)     ? ce : t_mem[rr*c + cc - 1];
        ea = (cc == c-1)   ? ce : t_mem[rr*c + cc + 1];
        exp_q.push_back(win(rr == r-1 && cc == c-1, rr == 0 && cc == 0, ce, no, so, ea, we));
      end
    end
  endtask

  task automatic spots_4x3();
    spot_idx.delete(); spot_val.delete();
    spot_idx.push_back(0);  spot_val.push_back(win(1'b0, 1'b1, 0, 0, 4, 1, 0));
    spot_idx.push_back(6);  spot_val.push_back(win(1'b0, 1'b0, 6, 2, 10, 7, 5));
    spot_idx.push_back(11); spot_val.push_back(win(1'b1, 1'b0, 11, 7, 11, 11, 10));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, axis_if.s_axis_temp_ready, 0);
    check_eq({tag, "_m_valid"}, axis_if.m_axis_temp_valid, 0);
    check_eq({tag, "_m_data"},  axis_if.m_axis_temp_data, 0);
    check_eq({tag, "_last"},    axis_if.m_axis_temp_last, 0);
    check_eq({tag, "_user"},    axis_if.m_axis_temp_user, 0);
    check_eq({tag, "_busy"},    busy, 0);
    check_eq({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  // Runs one frame. mode 0: all ready/valid high; 1: ready toggles, valid gapped;
  // 2: both random. abort_after >= 0 resets the DUT after that many samples.
  task automatic run_frame(input int c, input int r, input int mode,
                           input int abort_after, input bit start_midway);
    int total = c*r;
    int in_idx = 0, out_idx = 0, cyc = 0, flush_cnt = 0;
    int acc_c_cyc = -1, first_v_cyc = -1;
    int budget = total*8 + 200;
    bit hold_v = 1'b0;
    logic [161:0] hold_w = '0;
    cfg_cols = CB'(c); cfg_rows = RB'(r); start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    while (out_idx < total && cyc < budget) begin
      axis_if.s_axis_temp_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      axis_if.s_axis_temp_data  = (in_idx < total) ? t_mem[in_idx] : $urandom;
      axis_if.m_axis_temp_ready = (mode == 0) ? 1'b1 :
                                  (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (start_midway && cyc == 6) begin
        start = 1'b1; cfg_cols = CB'(3); cfg_rows = RB'(2);
      end else begin
        start = 1'b0;
      end
      @(negedge aclk);
      if (hold_v)
        check_eq("stall_hold",
                 {axis_if.m_axis_temp_valid, axis_if.m_axis_temp_last,
                  axis_if.m_axis_temp_user, axis_if.m_axis_temp_data},
                 {1'b1, hold_w});
      if (axis_if.m_axis_temp_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (axis_if.m_axis_temp_valid && axis_if.m_axis_temp_ready) begin
        check_eq($sformatf("win%0d", out_idx),
                 {axis_if.m_axis_temp_last, axis_if.m_axis_temp_user, axis_if.m_axis_temp_data},
                 exp_q[out_idx]);
        for (int i = 0; i < spot_idx.size(); i++)
          if (spot_idx[i] == out_idx)
            check_eq($sformatf("spot%0d", out_idx),
                     {axis_if.m_axis_temp_last, axis_if.m_axis_temp_user,
                      axis_if.m_axis_temp_data}, spot_val[i]);
        if (out_idx >= (r-1)*c && !axis_if.s_axis_temp_ready) flush_cnt++;
        out_idx++;
      end
      hold_v = axis_if.m_axis_temp_valid && !axis_if.m_axis_temp_ready;
      hold_w = {axis_if.m_axis_temp_last, axis_if.m_axis_temp_user, axis_if.m_axis_temp_data};
      if (axis_if.s_axis_temp_valid && axis_if.s_axis_temp_ready) begin
        if (in_idx == c) acc_c_cyc = cyc;
        in_idx++;
      end
      if (abort_after >= 0 && in_idx == abort_after) begin
        @(posedge aclk); #1;
        axi_reset = 1'b1;
        axis_if.s_axis_temp_valid = 1'b0;
        axis_if.m_axis_temp_ready = 1'b0;
        @(posedge aclk); #1;
        check_reset_outputs("abort");
        axi_reset = 1'b0;
        axis_if.m_axis_temp_ready = 1'b1;
        spot_idx.delete(); spot_val.delete();
        return;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    axis_if.s_axis_temp_valid = 1'b0;
    axis_if.m_axis_temp_ready = 1'b1;
    start = 1'b0;
    check_eq("win_count", out_idx, total);
    check_eq("samples", in_idx, total);
    check_eq("first_latency", first_v_cyc, acc_c_cyc + 1);
    check_eq("flush_noready", flush_cnt, c);
    check_eq("busy_end", busy, 0);
    check_eq("valid_end", axis_if.m_axis_temp_valid, 0);
    spot_idx.delete(); spot_val.delete();
  endtask

  task automatic bad_start(input int c, input int r);
    cfg_cols = CB'(c); cfg_rows = RB'(r); start = 1'b1;
    axis_if.s_axis_temp_valid = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check_eq($sformatf("cfg_err_c%0d_r%0d", c, r), {cfg_err, busy, axis_if.s_axis_temp_ready}, 3'b100);
    @(posedge aclk); #1;
    check_eq($sformatf("cfg_err_end_c%0d_r%0d", c, r), {cfg_err, busy, axis_if.s_axis_temp_ready}, 3'b000);
    axis_if.s_axis_temp_valid = 1'b0;
  endtask

  initial begin
    int c, r;
    axi_reset = 1'b1; start = 1'b0; cfg_cols = CB'(4); cfg_rows = RB'(3);
    axis_if.s_axis_temp_valid = 1'b0;
    axis_if.s_axis_temp_data  = '0;
    axis_if.m_axis_temp_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    axi_reset = 1'b0;
    @(posedge aclk); #1;

    build_exp(4, 3, 1'b0); spots_4x3(); run_frame(4, 3, 0, -1, 1'b0);
    build_exp(4, 3, 1'b0); spots_4x3(); run_frame(4, 3, 1, -1, 1'b0);

    build_exp(512, 2, 1'b0);
    spot_idx.push_back(511); spot_val.push_back(win(1'b0, 1'b0, 511, 511, 1023, 511, 510));
    run_frame(512, 2, 0, -1, 1'b0);

    bad_start(1, 3);
    bad_start(513, 3);
    bad_start(4, 1);
    build_exp(4, 3, 1'b1); run_frame(4, 3, 2, -1, 1'b0);

    build_exp(4, 3, 1'b0); run_frame(4, 3, 0, 7, 1'b0);
    build_exp(4, 3, 1'b0); spots_4x3(); run_frame(4, 3, 0, -1, 1'b0);

    build_exp(5, 3, 1'b1); run_frame(5, 3, 2, -1, 1'b1);

    repeat (4) begin
      c = $urandom_range(2, 12);
      r = $urandom_range(2, 5);
      build_exp(c, r, 1'b1);
      run_frame(c, r, 2, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/stencil_window_gen.md
# stencil_window_gen

Runtime-configurable 5-point stencil window generator for the Hotspot2D datapath. It accepts a row-major stream of grid temperatures and emits one {center, north, south, east, west} window per grid cell, in raster order, to the compute stage. Grid edges are clamped: a missing neighbour is replaced by the center value. After the last input sample, an internal flush emits the final row without further input. It sits between the input DMA stream and the hotspot update core, and supersedes the fixed-size, unclamped window buffer.

## Interface
- DATA_WIDTH, 32, width of one temperature sample.
- MAX_COLS, 512, maximum grid width; shift buffer depth is 2*MAX_COLS+1.
- COL_BITS, 10, width of cfg_cols and the column counter; must satisfy 2^COL_BITS > MAX_COLS.
- ROW_BITS, 10, width of cfg_rows and the row counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- cfg_cols  in  COL_BITS  grid width C; legal range 2..MAX_COLS; sampled on start.
- cfg_rows  in  ROW_BITS  grid height R; legal range ≥2; sampled on start.
- start  in  1  single-cycle frame start request.
- busy  out  1  high from an accepted start until the last window beat is accepted.
- cfg_err  out  1  one-cycle pulse when a start is rejected because the configuration is illegal.
- s_axis_temp_data  in  DATA_WIDTH  input sample.
- s_axis_temp_valid  in  1  input valid.
- s_axis_temp_ready  out  1  input ready.
- m_axis_temp_data  out  5*DATA_WIDTH  window {center, north, south, east, west}, center in the MSBs.
- m_axis_temp_valid  out  1  window valid.
- m_axis_temp_ready  in  1  downstream ready.
- m_axis_temp_last  out  1  marks the window of cell (R-1, C-1).
- m_axis_temp_user  out  1  marks the window of cell (0, 0).

## Operation
- State machine: IDLE → FILL → RUN → FLUSH → IDLE.
- IDLE
  - start with a legal configuration: latch C and R, clear counters, go to FILL, busy=1.
  - start with an illegal configuration: pulse cfg_err, stay in IDLE.
  - start while busy: ignored.
- Input sample k (k = r*C + c) is accepted on s_axis_temp_valid & s_axis_temp_ready. Acceptance shifts the buffer: new sample at tap 0, older samples move up.
- FILL
  - Accepts samples 0..C-1 and emits no windows.
  - Goes to RUN after sample C-1 is accepted.
- RUN
  - Each accepted sample k (k ≥ C) produces the window for cell k-C.
  - Goes to FLUSH after sample R*C-1 is accepted.
- FLUSH
  - s_axis_temp_ready=0.
  - The buffer self-advances with don't-care fill whenever the output register can load.
  - Emits the windows for cells (R-1)*C .. R*C-1.
  - Returns to IDLE when the window with last=1 is accepted.
- Window for cell (r, c) with value T[r][c]:
  - north = T[r-1][c], or center if r=0.
  - south = T[r+1][c], or center if r=R-1.
  - west = T[r][c-1], or center if c=0.
  - east = T[r][c+1], or center if c=C-1.
- Buffer taps are selected at runtime from C: south at tap 0, center at tap C, north at tap 2C, east at tap C-1, west at tap C+1.
- Buffer contents are not reset; clamping guarantees stale data is never emitted.
- Output row/column counters track the cell being emitted; they wrap the column at C-1 and increment the row.
- No arithmetic beyond the counters; data passes through unmodified.

## Timing
- Reset values: s_axis_temp_ready=0, m_axis_temp_valid=0, m_axis_temp_data=0, last=0, user=0, busy=0, cfg_err=0, state=IDLE. Reset mid-frame aborts the frame immediately.
- Output is a single register stage. The window for cell k-C is valid on the cycle after input sample k is accepted.
- s_axis_temp_ready = (state ∈ {FILL, RUN}) & (~m_axis_temp_valid | m_axis_temp_ready).
  - It is combinational from m_axis_temp_ready only.
  - It must not depend on s_axis_temp_valid.
- Throughput: one window per cycle when valid and ready are both held high, including during FLUSH.
- AXI-Stream rules:
  - m_axis_temp_data, last and user are held stable while valid=1 and ready=0.
  - valid never drops without a handshake.
- FILL→RUN and RUN→FLUSH transitions occur on the accepting edge, with no bubble cycle.
- busy falls on the cycle after the last-window handshake.
- A new start is accepted in IDLE on the cycle busy is low.

## Test plan
- C=4, R=3, input values 0..11, ready held high:
  - 12 windows are emitted; the first appears the cycle after sample 4 is accepted.
  - Cell (0,0) = {0,0,4,1,0} with user=1.
  - Cell (1,2) = {6,2,10,7,5}.
  - Cell (2,3) = {11,7,11,11,10} with last=1.
- Same grid with m_axis_temp_ready toggling 1-0-1-0 and s_axis_temp_valid randomly gapped:
  - Identical 12-window sequence.
  - Data stable while stalled.
  - No sample is lost or duplicated.
- C=MAX_COLS=512, R=2, ramp input:
  - 1024 windows.
  - Cell (0,511) = {511,511,1023,511,510}.
  - FLUSH emits 512 windows with s_axis_temp_ready=0.
- Illegal configurations C=1, then C=513, then R=1:
  - Each produces a one-cycle cfg_err pulse; busy stays 0 and no handshake occurs.
  - A following legal start proceeds normally.
- Reset asserted mid-RUN (after 7 samples of a 4x3 frame):
  - Next cycle: all outputs are at their reset values.
  - A fresh 4x3 frame then reproduces the first scenario exactly.
- start pulsed while busy:
  - Ignored; the current frame completes unchanged.
